// File: rtl/exp_pkg.sv
// Shared definitions for the exp pipeline and the units that time-share it.
// Q5.11 format defaults, the exp latency and the tag carried alongside each operand.
package exp_pkg;

    localparam int DEF_DWIDTH   = 16;
    localparam int DEF_INT_BIT  = 5;
    localparam int DEF_FRAC_BIT = 11;
    localparam int DEF_EXP_LAT  = 2;

    localparam logic [DEF_DWIDTH-1:0] EXP_ONE = 16'h0800;

    // Wide enough for up to eight requesters; narrower arbiters leave the top bits zero.
    localparam int TAG_ID_W = 3;
    localparam int MAX_NREQ = 1 << TAG_ID_W;

    typedef logic [TAG_ID_W-1:0] tag_id_t;

    typedef struct packed {
        logic    valid;
        tag_id_t id;
    } tag_t;

endpackage

// File: rtl/exp_arbiter_if.sv
// Bundle of requester, exp-unit and response signals around exp_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface exp_arbiter_if
    import exp_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DWIDTH = DEF_DWIDTH
);

    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ*DWIDTH-1:0] i_req_data;
    logic [NREQ-1:0]        o_req_ready;

    logic                   o_exp_enable;
    logic [DWIDTH-1:0]      o_exp_in;
    logic [DWIDTH-1:0]      i_exp_out;

    logic [NREQ-1:0]        o_rsp_valid;
    logic [DWIDTH-1:0]      o_rsp_data;
    logic                   i_rsp_ready;

    logic                   o_busy;

    modport slave (
        input  i_req_valid,
        input  i_req_data,
        output o_req_ready,
        output o_exp_enable,
        output o_exp_in,
        input  i_exp_out,
        output o_rsp_valid,
        output o_rsp_data,
        input  i_rsp_ready,
        output o_busy
    );

    modport master (
        output i_req_valid,
        output i_req_data,
        input  o_req_ready,
        input  o_exp_enable,
        input  o_exp_in,
        output i_exp_out,
        input  o_rsp_valid,
        input  o_rsp_data,
        output i_rsp_ready,
        input  o_busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the last accepted index.
// The pointer only moves when the owner signals that the grant was actually taken.
module rr_arbiter
    import exp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             accept,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_id,
    output logic             grant_valid
);

    logic [IDX_W-1:0] last_grant;

    // Two passes: indices above the pointer first, then wrap around to the rest.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i > int'(last_grant))) begin
                grant_valid = 1'b1;
                grant_id    = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i <= int'(last_grant))) begin
                grant_valid = 1'b1;
                grant_id    = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = grant_valid && (grant_id == IDX_W'(i));
        end
    end

    // Resetting to the top index gives requester 0 first priority.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_grant <= IDX_W'(NREQ - 1);
        end else if (accept && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Shares one fixed-latency exp pipeline among NREQ requesters, routing each result
// back through a tag pipeline that freezes together with the exp unit.
module exp_arbiter
    import exp_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DWIDTH  = DEF_DWIDTH,
    parameter int EXP_LAT = DEF_EXP_LAT
) (
    input  logic          clk,
    input  logic          arst_n,
    exp_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic             adv;
    logic             issue;
    logic             any_inflight;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_id;
    logic             grant_valid;
    tag_t             stage_in;
    tag_t             last_tag;
    tag_t [EXP_LAT-1:0] tags;

    // Reset is folded into adv so every strobe reads zero while reset is held.
    assign adv   = bus.i_rsp_ready & arst_n;
    assign issue = adv & grant_valid;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk         (clk),
        .arst_n      (arst_n),
        .req         (bus.i_req_valid),
        .accept      (issue),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign bus.o_req_ready = grant & {NREQ{adv}};

    always_comb begin
        bus.o_exp_in = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && grant[i]) begin
                bus.o_exp_in = bus.i_req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        stage_in       = '0;
        stage_in.valid = issue;
        stage_in.id    = TAG_ID_W'(grant_id);
    end

    // Shifts only with adv, mirroring exactly when the exp unit's registers advance.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tags <= '0;
        end else if (adv) begin
            tags[0] <= stage_in;
            for (int i = 1; i < EXP_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
        end
    end

    always_comb begin
        any_inflight = 1'b0;
        for (int i = 0; i < EXP_LAT; i++) begin
            any_inflight = any_inflight | tags[i].valid;
        end
    end

    assign last_tag         = tags[EXP_LAT-1];
    assign bus.o_busy       = any_inflight;
    assign bus.o_exp_enable = adv & (issue | any_inflight);
    assign bus.o_rsp_data   = last_tag.valid ? bus.i_exp_out : '0;

    always_comb begin
        bus.o_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.o_rsp_valid[i] = adv & last_tag.valid & (last_tag.id == TAG_ID_W'(i));
        end
    end

endmodule
